// File: rtl/scv_vram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | scv_vram_pkg: shared widths, CPU-side state type and helpers for the VRAM   |
// | arbiter.                                                                    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package scv_vram_pkg;

  localparam int VRAM_AW = 11;
  localparam int VRAM_DW = 8;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_WAIT = 2'd1,
    C_RDAT = 2'd2,
    C_DONE = 2'd3
  } cpu_state_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scv_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | scv_sat_counter: enabled up-counter that sticks at all-ones.                |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module scv_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/scv_vram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | scv_vram_arbiter: shares the single-port SCV VRAM between the CPU bus and   |
// | the video fetch port. Optional stats counters: SCV_VRAM_ARB_STATS_EN.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module scv_vram_arbiter
  import scv_vram_pkg::*;
#(
  parameter int VID_BURST_MAX = 4
) (
  input  logic               CLK,
  input  logic               RESETB,
  input  logic               CPU_CSB,
  input  logic               CPU_RDB,
  input  logic               CPU_WRB,
  input  logic [VRAM_AW-1:0] CPU_A,
  input  logic [VRAM_DW-1:0] CPU_DI,
  output logic [VRAM_DW-1:0] CPU_DO,
  output logic               CPU_WAITB,
  input  logic               VID_REQ,
  input  logic [VRAM_AW-1:0] VID_A,
  output logic               VID_ACK,
  output logic [VRAM_DW-1:0] VID_DO,
  output logic               VID_VALID,
  output logic [VRAM_AW-1:0] RAM_A,
  output logic               RAM_WE,
  output logic [VRAM_DW-1:0] RAM_DI,
  input  logic [VRAM_DW-1:0] RAM_DO,
  output logic [15:0]        STAT_CPU_WAIT,
  output logic [15:0]        STAT_VID_GNT
);

  cpu_state_t         state_q, state_d;
  logic               strb_q;
  logic [3:0]         streak_q, streak_d;
  logic [VRAM_AW-1:0] ram_a_q;
  logic               tag_vid_q, tag_cpu_q;
  logic [VRAM_DW-1:0] cpu_do_q, vid_do_q;
  logic               vid_valid_q;

  logic cs_rd, cs_wr, cs_any, new_acc, cpu_pend;
  logic vid_gnt, cpu_gnt, cpu_wr_gnt, cpu_rd_gnt;

  assign cs_rd   = ~CPU_CSB & ~CPU_RDB;
  assign cs_wr   = ~CPU_CSB & ~CPU_WRB;
  assign cs_any  = cs_rd | cs_wr;
  assign new_acc = cs_any & ~strb_q;

  // The edge cycle already competes for the RAM so an uncontended access is granted at once.
  assign cpu_pend = cs_any & (((state_q == C_IDLE) & new_acc) | (state_q == C_WAIT));

  assign vid_gnt    = RESETB & VID_REQ & ((streak_q < 4'(VID_BURST_MAX)) | ~cpu_pend);
  assign cpu_gnt    = RESETB & cpu_pend & ~vid_gnt;
  assign cpu_wr_gnt = cpu_gnt & cs_wr;
  assign cpu_rd_gnt = cpu_gnt & ~cs_wr;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    case (state_q)
      C_IDLE, C_WAIT: begin
        if (!cpu_pend)       state_d = C_IDLE;
        else if (cpu_wr_gnt) state_d = C_DONE;
        else if (cpu_rd_gnt) state_d = C_RDAT;
        else                 state_d = C_WAIT;
      end
      C_RDAT:  state_d = C_DONE;
      C_DONE:  if (!cs_any) state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
    if (!cpu_pend || cpu_gnt) streak_d = '0;
    else if (vid_gnt)         streak_d = sat_inc4(streak_q);
  end

  always_comb begin
    RAM_A = ram_a_q;
    if (vid_gnt)      RAM_A = VID_A;
    else if (cpu_gnt) RAM_A = CPU_A;
  end

  assign RAM_WE    = cpu_wr_gnt;
  assign RAM_DI    = cpu_wr_gnt ? CPU_DI : '0;
  assign VID_ACK   = vid_gnt;
  assign CPU_WAITB = ~(cpu_pend | (cs_any & (state_q == C_RDAT)));
  assign CPU_DO    = cpu_do_q;
  assign VID_DO    = vid_do_q;
  assign VID_VALID = vid_valid_q;

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q     <= C_IDLE;
      strb_q      <= 1'b1;
      streak_q    <= '0;
      ram_a_q     <= '0;
      tag_vid_q   <= 1'b0;
      tag_cpu_q   <= 1'b0;
      cpu_do_q    <= '0;
      vid_do_q    <= '0;
      vid_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      strb_q      <= cs_any;
      streak_q    <= streak_d;
      ram_a_q     <= RAM_A;
      tag_vid_q   <= vid_gnt;
      tag_cpu_q   <= cpu_rd_gnt;
      vid_valid_q <= tag_vid_q;
      if (tag_vid_q) vid_do_q <= RAM_DO;
      if (tag_cpu_q) cpu_do_q <= RAM_DO;
    end
  end

`ifdef SCV_VRAM_ARB_STATS_EN
  logic cpu_wait_en;
  assign cpu_wait_en = ~CPU_WAITB;

  scv_sat_counter #(.WIDTH(16)) u_stat_cpu_wait (
    .clk_i  (CLK),
    .rst_ni (RESETB),
    .en_i   (cpu_wait_en),
    .cnt_o  (STAT_CPU_WAIT)
  );

  scv_sat_counter #(.WIDTH(16)) u_stat_vid_gnt (
    .clk_i  (CLK),
    .rst_ni (RESETB),
    .en_i   (vid_gnt),
    .cnt_o  (STAT_VID_GNT)
  );
`else
  assign STAT_CPU_WAIT = '0;
  assign STAT_VID_GNT  = '0;
`endif

endmodule
`default_nettype wire
